// File: rtl/risc_shift_issue_buffer.sv
// Issue stage in front of RISC_shifter: a 2-entry skid buffer (main + skid register)
// that presents registered operand, shift amount and function select to the shifter.
module risc_shift_issue_buffer #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TAG_W       = 5,
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      in_a,
    input  logic [4:0]             in_sh,
    input  logic [3:0]             in_fs,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      out_shift_in,
    output logic [4:0]             out_sh,
    output logic [3:0]             out_fs,
    output logic [TAG_W-1:0]       out_tag,
    output logic                   out_is_shift,
    output logic [1:0]             occupancy,
    output logic [STALL_CNT_W-1:0] stall_count
);

    logic                   r_main_valid;
    logic [DATA_W-1:0]      r_main_a;
    logic [4:0]             r_main_sh;
    logic [3:0]             r_main_fs;
    logic [TAG_W-1:0]       r_main_tag;

    logic                   r_skid_valid;
    logic [DATA_W-1:0]      r_skid_a;
    logic [4:0]             r_skid_sh;
    logic [3:0]             r_skid_fs;
    logic [TAG_W-1:0]       r_skid_tag;

    logic [STALL_CNT_W-1:0] r_stall_count;

    logic                   w_accept;
    logic                   w_pop;

    // Ready depends only on registered state, never on out_ready.
    assign in_ready = !r_skid_valid && !reset;
    assign w_accept = in_valid && in_ready;
    assign w_pop    = r_main_valid && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_main_valid  <= 1'b0;
            r_main_a      <= '0;
            r_main_sh     <= '0;
            r_main_fs     <= '0;
            r_main_tag    <= '0;
            r_skid_valid  <= 1'b0;
            r_skid_a      <= '0;
            r_skid_sh     <= '0;
            r_skid_fs     <= '0;
            r_skid_tag    <= '0;
            r_stall_count <= '0;
        end else begin
            if (r_main_valid && !out_ready && (r_stall_count != '1)) begin
                r_stall_count <= r_stall_count + STALL_CNT_W'(1);
            end

            if (flush) begin
                r_main_valid <= 1'b0;
                r_skid_valid <= 1'b0;
            end else if (!r_main_valid) begin
                if (w_accept) begin
                    r_main_valid <= 1'b1;
                    r_main_a     <= in_a;
                    r_main_sh    <= in_sh;
                    r_main_fs    <= in_fs;
                    r_main_tag   <= in_tag;
                end
            end else if (!r_skid_valid) begin
                if (w_accept && w_pop) begin
                    r_main_a     <= in_a;
                    r_main_sh    <= in_sh;
                    r_main_fs    <= in_fs;
                    r_main_tag   <= in_tag;
                end else if (w_accept) begin
                    r_skid_valid <= 1'b1;
                    r_skid_a     <= in_a;
                    r_skid_sh    <= in_sh;
                    r_skid_fs    <= in_fs;
                    r_skid_tag   <= in_tag;
                end else if (w_pop) begin
                    r_main_valid <= 1'b0;
                end
            end else if (w_pop) begin
                // Both full: the skid entry becomes the oldest op.
                r_main_a     <= r_skid_a;
                r_main_sh    <= r_skid_sh;
                r_main_fs    <= r_skid_fs;
                r_main_tag   <= r_skid_tag;
                r_skid_valid <= 1'b0;
            end
        end
    end

    assign out_valid    = r_main_valid;
    assign out_shift_in = r_main_a;
    assign out_sh       = r_main_sh;
    assign out_fs       = r_main_fs;
    assign out_tag      = r_main_tag;
    assign out_is_shift = r_main_fs[3] && (r_main_fs != 4'b1000);
    assign occupancy    = {1'b0, r_main_valid} + {1'b0, r_skid_valid};
    assign stall_count  = r_stall_count;

endmodule

// File: tb/tb_risc_shift_issue_buffer.sv
// Bench for risc_shift_issue_buffer: directed scenarios plus random traffic, all
// compared against a queue-based model of the 2-deep FIFO and its stall counter.
module tb_risc_shift_issue_buffer;

    typedef struct packed {
        logic [31:0] a;
        logic [4:0]  sh;
        logic [3:0]  fs;
        logic [4:0]  tag;
    } op_t;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic [31:0] in_a;
    logic [4:0]  in_sh;
    logic [3:0]  in_fs;
    logic [4:0]  in_tag;
    logic        in_ready, out_valid, out_is_shift;
    logic [31:0] out_shift_in;
    logic [4:0]  out_sh;
    logic [3:0]  out_fs;
    logic [4:0]  out_tag;
    logic [1:0]  occupancy;
    logic [15:0] stall_count;

    logic        s_in_ready, s_out_valid, s_out_is_shift;
    logic [31:0] s_out_shift_in;
    logic [4:0]  s_out_sh;
    logic [3:0]  s_out_fs;
    logic [4:0]  s_out_tag;
    logic [1:0]  s_occupancy;
    logic [2:0]  s_stall_count;

    op_t obs;
    assign obs = {out_shift_in, out_sh, out_fs, out_tag};

    always #5 clk = ~clk;

    risc_shift_issue_buffer #(.DATA_W(32), .TAG_W(5), .STALL_CNT_W(16)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_sh(in_sh), .in_fs(in_fs), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_shift_in(out_shift_in),
        .out_sh(out_sh), .out_fs(out_fs), .out_tag(out_tag), .out_is_shift(out_is_shift),
        .occupancy(occupancy), .stall_count(stall_count)
    );

    risc_shift_issue_buffer #(.DATA_W(32), .TAG_W(5), .STALL_CNT_W(3)) dut_sat (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_a(in_a), .in_sh(in_sh), .in_fs(in_fs), .in_tag(in_tag),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_shift_in(s_out_shift_in),
        .out_sh(s_out_sh), .out_fs(s_out_fs), .out_tag(s_out_tag), .out_is_shift(s_out_is_shift),
        .occupancy(s_occupancy), .stall_count(s_stall_count)
    );

    int          checks = 0;
    int          errors = 0;
    op_t         q[$];
    op_t         last_op;
    int unsigned m_stall, m_stall3;
    bit          seen_ready, exp_ready_pre;

    function automatic op_t rand_op();
        op_t o;
        o.a   = $urandom;
        o.sh  = 5'($urandom_range(31));
        o.fs  = 4'($urandom_range(15));
        o.tag = 5'($urandom_range(31));
        return o;
    endfunction

    function automatic op_t shown();
        return (q.size() > 0) ? q[0] : last_op;
    endfunction

    // Drive one cycle from a negedge, sample in_ready before the edge, update the model,
    // and return at the following negedge.
    task automatic cycle(input bit v, input op_t op, input bit rdy, input bit fl, input bit rst);
        bit acc, pop;
        reset = rst; flush = fl; in_valid = v; out_ready = rdy;
        in_a = op.a; in_sh = op.sh; in_fs = op.fs; in_tag = op.tag;
        #1;
        seen_ready    = in_ready;
        exp_ready_pre = !rst && (q.size() < 2);
        @(posedge clk);
        if (rst) begin
            q.delete(); m_stall = 0; m_stall3 = 0; last_op = '0;
        end else begin
            acc = v && (q.size() < 2);
            pop = (q.size() > 0) && rdy;
            if (q.size() > 0 && !rdy) begin
                if (m_stall < 65535) m_stall++;
                if (m_stall3 < 7) m_stall3++;
            end
            if (fl) begin
                if (q.size() > 0) last_op = q[0];
                q.delete();
            end else begin
                if (pop) begin last_op = q[0]; void'(q.pop_front()); end
                if (acc) q.push_back(op);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        cycle(0, '0, 0, 0, 1);
        cycle(0, '0, 0, 0, 1);
        checks++; if (seen_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", seen_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
        checks++; if (obs !== op_t'(0)) begin errors++; $display("FAIL reset_data got %h want 0", obs); end
        checks++; if (out_is_shift !== 1'b0) begin errors++; $display("FAIL reset_is_shift got %b want 0", out_is_shift); end
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occ got %0d want 0", occupancy); end
        checks++; if (stall_count !== 16'd0) begin errors++; $display("FAIL reset_stall got %0d want 0", stall_count); end
        reset = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready got %b want 1", in_ready); end
    endtask

    task automatic test_first_op();
        op_t o;
        o = {32'h0000_00F0, 5'd4, 4'd9, 5'd3};
        cycle(1, o, 1, 0, 0);
        checks++; if (seen_ready !== 1'b1) begin errors++; $display("FAIL first_in_ready got %b want 1", seen_ready); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL first_valid got %b want 1", out_valid); end
        checks++; if (obs !== o) begin errors++; $display("FAIL first_data got %h want %h", obs, o); end
        checks++; if (out_is_shift !== 1'b1) begin errors++; $display("FAIL first_is_shift got %b want 1", out_is_shift); end
        checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL first_occ got %0d want 1", occupancy); end
    endtask

    task automatic test_stream();
        op_t sent[8];
        for (int i = 0; i < 8; i++) begin
            sent[i] = rand_op();
            cycle(1, sent[i], 1, 0, 0);
            checks++; if (seen_ready !== 1'b1) begin errors++; $display("FAIL stream_ready[%0d] got %b want 1", i, seen_ready); end
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d] got %b want 1", i, out_valid); end
            checks++; if (obs !== sent[i]) begin errors++; $display("FAIL stream_data[%0d] got %h want %h", i, obs, sent[i]); end
        end
        checks++; if (stall_count !== 16'd0) begin errors++; $display("FAIL stream_stall got %0d want 0", stall_count); end
        cycle(0, '0, 1, 0, 0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain got %b want 0", out_valid); end
    endtask

    task automatic test_backpressure();
        op_t a, b, c;
        a = rand_op(); b = rand_op(); c = rand_op();
        cycle(1, a, 0, 0, 0);
        checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL bp_occ1 got %0d want 1", occupancy); end
        cycle(1, b, 0, 0, 0);
        checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL bp_occ2 got %0d want 2", occupancy); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_full got %b want 0", in_ready); end
        checks++; if (obs !== a) begin errors++; $display("FAIL bp_head_a got %h want %h", obs, a); end
        cycle(1, c, 0, 0, 0);
        checks++; if (seen_ready !== 1'b0) begin errors++; $display("FAIL bp_c_held got %b want 0", seen_ready); end
        checks++; if (obs !== a || occupancy !== 2'd2) begin errors++; $display("FAIL bp_hold got %h/%0d want %h/2", obs, occupancy, a); end
        cycle(1, c, 1, 0, 0);
        checks++; if (obs !== b || occupancy !== 2'd1) begin errors++; $display("FAIL bp_out_b got %h/%0d want %h/1", obs, occupancy, b); end
        cycle(1, c, 1, 0, 0);
        checks++; if (seen_ready !== 1'b1) begin errors++; $display("FAIL bp_c_ready got %b want 1", seen_ready); end
        checks++; if (obs !== c || out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_c got %h/%b want %h/1", obs, out_valid, c); end
        cycle(0, c, 1, 0, 0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got %b want 0", out_valid); end
        checks++; if (stall_count !== 16'(m_stall)) begin errors++; $display("FAIL bp_stall got %0d want %0d", stall_count, m_stall); end
    endtask

    task automatic test_stall_count();
        cycle(0, '0, 0, 0, 1);
        cycle(1, rand_op(), 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(0, '0, 0, 0, 0);
        checks++; if (stall_count !== 16'd5) begin errors++; $display("FAIL stall5 got %0d want 5", stall_count); end
        checks++; if (s_stall_count !== 3'd5) begin errors++; $display("FAIL stall5_narrow got %0d want 5", s_stall_count); end
        for (int i = 0; i < 5; i++) cycle(0, '0, 0, 0, 0);
        checks++; if (stall_count !== 16'd10) begin errors++; $display("FAIL stall10 got %0d want 10", stall_count); end
        checks++; if (s_stall_count !== 3'd7) begin errors++; $display("FAIL stall_sat got %0d want 7", s_stall_count); end
        checks++; if (out_valid !== 1'b1 || occupancy !== 2'd1) begin errors++; $display("FAIL stall_hold got %b/%0d want 1/1", out_valid, occupancy); end
        cycle(0, '0, 1, 0, 0);
        checks++; if (stall_count !== 16'd10) begin errors++; $display("FAIL stall_after_pop got %0d want 10", stall_count); end
    endtask

    task automatic test_flush();
        op_t a, b, y;
        a = rand_op(); b = rand_op(); y = rand_op();
        cycle(1, a, 0, 0, 0);
        cycle(1, b, 0, 0, 0);
        cycle(1, rand_op(), 0, 1, 0);
        checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin errors++; $display("FAIL flush_full got %b/%0d want 0/0", out_valid, occupancy); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got %b want 1", in_ready); end
        checks++; if (obs !== a) begin errors++; $display("FAIL flush_data_hold got %h want %h", obs, a); end
        checks++; if (stall_count !== 16'(m_stall) || m_stall != 12) begin errors++; $display("FAIL flush_stall got %0d want 12", stall_count); end
        cycle(1, y, 0, 0, 0);
        cycle(1, rand_op(), 1, 1, 0);
        checks++; if (seen_ready !== 1'b1) begin errors++; $display("FAIL flush_acc_ready got %b want 1", seen_ready); end
        checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin errors++; $display("FAIL flush_acc got %b/%0d want 0/0", out_valid, occupancy); end
        cycle(0, '0, 1, 0, 0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_dropped got %b want 0", out_valid); end
        checks++; if (obs !== y) begin errors++; $display("FAIL flush_acc_hold got %h want %h", obs, y); end
    endtask

    task automatic test_nonshift();
        op_t o;
        for (int unsigned f = 0; f < 16; f++) begin
            o = rand_op();
            o.fs = 4'(f);
            cycle(1, o, 1, 0, 0);
            checks++; if (obs !== o) begin errors++; $display("FAIL fs_pass[%0d] got %h want %h", f, obs, o); end
            checks++; if (out_is_shift !== (f >= 9)) begin errors++; $display("FAIL is_shift[%0d] got %b want %b", f, out_is_shift, (f >= 9)); end
        end
        cycle(0, '0, 1, 0, 0);
    endtask

    task automatic test_reset_mid();
        cycle(1, rand_op(), 0, 0, 0);
        cycle(1, rand_op(), 0, 0, 0);
        cycle(1, rand_op(), 0, 0, 0);
        checks++; if (occupancy !== 2'd2 || stall_count == 16'd0) begin errors++; $display("FAIL mid_setup got %0d/%0d want 2/nonzero", occupancy, stall_count); end
        cycle(1, rand_op(), 1, 1, 1);
        checks++; if (seen_ready !== 1'b0) begin errors++; $display("FAIL mid_reset_ready got %b want 0", seen_ready); end
        checks++; if (out_valid !== 1'b0 || obs !== op_t'(0) || out_is_shift !== 1'b0) begin errors++; $display("FAIL mid_reset_out got %b/%h want 0/0", out_valid, obs); end
        checks++; if (occupancy !== 2'd0 || stall_count !== 16'd0 || s_stall_count !== 3'd0) begin errors++; $display("FAIL mid_reset_cnt got %0d/%0d want 0/0", occupancy, stall_count); end
        reset = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_post_ready got %b want 1", in_ready); end
    endtask

    task automatic test_random();
        op_t e;
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(3) != 0, rand_op(), $urandom_range(2) != 0,
                  $urandom_range(19) == 0, $urandom_range(99) == 0);
            e = shown();
            checks++; if (seen_ready !== exp_ready_pre) begin errors++; $display("FAIL rnd_ready[%0d] got %b want %b", i, seen_ready, exp_ready_pre); end
            checks++; if (out_valid !== (q.size() > 0)) begin errors++; $display("FAIL rnd_valid[%0d] got %b want %b", i, out_valid, (q.size() > 0)); end
            checks++; if (obs !== e) begin errors++; $display("FAIL rnd_data[%0d] got %h want %h", i, obs, e); end
            checks++; if (out_is_shift !== (e.fs >= 4'd9)) begin errors++; $display("FAIL rnd_is_shift[%0d] got %b want %b", i, out_is_shift, (e.fs >= 4'd9)); end
            checks++; if (occupancy !== 2'(q.size())) begin errors++; $display("FAIL rnd_occ[%0d] got %0d want %0d", i, occupancy, q.size()); end
            checks++; if (stall_count !== 16'(m_stall)) begin errors++; $display("FAIL rnd_stall[%0d] got %0d want %0d", i, stall_count, m_stall); end
            checks++; if (s_stall_count !== 3'(m_stall3)) begin errors++; $display("FAIL rnd_stall_narrow[%0d] got %0d want %0d", i, s_stall_count, m_stall3); end
        end
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_sh = '0; in_fs = '0; in_tag = '0;
        last_op = '0; m_stall = 0; m_stall3 = 0;
        @(negedge clk);
        test_reset();
        test_first_op();
        test_stream();
        test_backpressure();
        test_stall_count();
        test_flush();
        test_nonshift();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/risc_shift_issue_buffer.md
Name: risc_shift_issue_buffer

Overview:
- Operand/function issue stage directly upstream of RISC_shifter; registers one decoded shift operation per cycle.
- Presents shift_in (32), SH (5) and S (4) to the shifter from registered state.
- 2-entry skid buffer with valid/ready on both sides, so decode stalls never create a combinational ready path.
- Also carries a destination tag, flags non-shift function codes, and counts downstream stall cycles.

Parameters:
- DATA_W, 32, operand width; must match shifter input width.
- TAG_W, 5, destination register tag width.
- STALL_CNT_W, 16, width of saturating stall counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous pipeline flush; discards all buffered ops.
- in_valid  in  1  decode presents an op.
- in_ready  out  1  buffer can accept an op this cycle.
- in_a  in  DATA_W  operand to be shifted.
- in_sh  in  5  shift amount.
- in_fs  in  4  function select.
- in_tag  in  TAG_W  destination register tag.
- out_valid  out  1  op on out_* is valid.
- out_ready  in  1  downstream consumes op this cycle.
- out_shift_in  out  DATA_W  to shifter shift_in.
- out_sh  out  5  to shifter SH.
- out_fs  out  4  to shifter S.
- out_tag  out  TAG_W  tag travelling with the op.
- out_is_shift  out  1  1 when out_fs is in 4'b1001..4'b1111.
- occupancy  out  2  number of buffered ops (0, 1 or 2).
- stall_count  out  STALL_CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.

Behaviour:
- Storage: main register (drives out_*) plus skid register; each has its own valid bit.
- in_ready = !skid_valid && !reset. Registered-state only; no combinational path from out_ready.
- Accept when in_valid && in_ready. Pop when out_valid && out_ready.
- Ordering is strict FIFO: the main register always holds the oldest op.
- Latency: op accepted in cycle N into an empty buffer appears on out_* with out_valid=1 in cycle N+1.
- Throughput: 1 op/cycle sustained while out_ready=1.
- Empty + accept: load main.
- Main full, skid empty:
  - accept and pop: load main with the new op.
  - accept, no pop: load skid.
  - pop, no accept: main_valid goes to 0.
- Both full (in_ready=0):
  - pop: skid moves to main; skid_valid goes to 0.
  - no pop: hold.
- Output data holds its last value when out_valid=0; it must not be consumed by downstream.
- out_is_shift is combinational from out_fs: (out_fs[3] && out_fs != 4'b1000).
  - Non-shift codes pass through unchanged with out_is_shift=0.
- occupancy = main_valid + skid_valid.
- stall_count:
  - increments each cycle with out_valid && !out_ready.
  - saturates at all-ones.
  - cleared only by reset; flush does not clear it.
- Flush: both valid bits cleared on the next edge; data registers unchanged.
  - Flush wins over a simultaneous accept: the input op is dropped, but the upstream handshake still completes because in_ready was 1.
  - Flush wins over a simultaneous pop: the pop completes for downstream; no further ops remain.
- Reset (including mid-operation):
  - All valid bits 0; all data registers 0, so out_shift_in=0, out_sh=0, out_fs=0, out_tag=0, out_is_shift=0.
  - occupancy=0, stall_count=0.
  - in_ready=0 while reset is high, 1 on the first cycle after.
  - Reset overrides flush and every handshake.

Test Plan:
- Reset, then in_valid=1 with in_a=32'h0000_00F0, in_sh=4, in_fs=4'b1001, tag=3, out_ready=1 -> next cycle out_valid=1, out_shift_in=32'h0000_00F0, out_sh=4, out_fs=9, out_tag=3, out_is_shift=1, occupancy=1.
- Stream 8 ops with out_ready held 1 -> one op out per cycle, same order; in_ready stays 1; stall_count=0.
- out_ready=0, push ops A then B -> occupancy=2, in_ready=0, out_* shows A; C is held off. Raise out_ready -> A, B, C delivered in order.
- out_ready=0 for 5 cycles with out_valid=1 -> stall_count=5. Force STALL_CNT_W=3 and hold 10 cycles -> stall_count=7.
- With 2 ops buffered, pulse flush together with in_valid=1 -> next cycle out_valid=0, occupancy=0, in_ready=1; the flushed-cycle op never appears.
- in_fs=4'b0101 -> forwarded with out_fs=5, out_is_shift=0. Assert reset while occupancy=2 -> all outputs 0 next cycle, stall_count=0.
